// File: rtl/team_06_ramped_volume_ctrl.sv
// Volume control with a slow linear gain ramp toward a button-driven target,
// applied to offset-binary audio through a two-stage multiply/shift pipeline.
module team_06_ramped_volume_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned VOL_W       = 4,
  parameter int unsigned RAMP_DIV    = 256,
  parameter int unsigned DEFAULT_VOL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vol_up,
  input  logic              vol_dn,
  input  logic              mute,
  input  logic              enable_volume,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] audio_in,
  output logic [DATA_W-1:0] audio_out,
  output logic              out_valid,
  output logic [VOL_W-1:0]  cur_volume,
  output logic              ramping
);

  localparam int unsigned CNT_W  = $clog2(RAMP_DIV);
  localparam int unsigned GAIN_W = VOL_W + 2;
  localparam int unsigned PROD_W = DATA_W + VOL_W + 2;

  localparam logic [VOL_W-1:0]  VMAX     = '1;
  localparam logic [VOL_W-1:0]  VOL_RST  = VOL_W'(DEFAULT_VOL);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W:0]   MID_EXT  = {1'b0, MID};

  logic [VOL_W-1:0] target;
  logic [VOL_W-1:0] eff_target_c;
  logic [CNT_W-1:0] ramp_cnt;

  // Stage 1 holding registers
  logic                     s1_valid;
  logic                     s1_bypass;
  logic [DATA_W-1:0]        s1_raw;
  logic [VOL_W-1:0]         s1_vol;
  logic signed [PROD_W-1:0] s1_prod;

  logic signed [DATA_W:0]   d_c;
  logic [GAIN_W-1:0]        gain_c;
  logic signed [PROD_W-1:0] prod_c;
  logic [PROD_W-1:0]        sum_c;
  logic [DATA_W-1:0]        scaled_c;
  logic                     unused_sum_hi;

  // Mute forces the ramp toward silence without disturbing the stored target
  always_comb begin
    eff_target_c = target;
    if (mute) begin
      eff_target_c = '0;
    end
  end

  assign ramping = (cur_volume != eff_target_c);

  // Button-driven target, saturating at both ends; simultaneous presses cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      target <= VOL_RST;
    end else begin
      case ({vol_up, vol_dn})
        2'b10: if (target != VMAX) target <= target + VOL_W'(1);
        2'b01: if (target != '0)   target <= target - VOL_W'(1);
        default: target <= target;
      endcase
    end
  end

  // One volume step per RAMP_DIV cycles of continuous mismatch
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_volume <= '0;
      ramp_cnt   <= '0;
    end else if (!ramping) begin
      ramp_cnt <= '0;
    end else if (ramp_cnt == CNT_LAST) begin
      ramp_cnt <= '0;
      if (eff_target_c > cur_volume) begin
        cur_volume <= cur_volume + VOL_W'(1);
      end else begin
        cur_volume <= cur_volume - VOL_W'(1);
      end
    end else begin
      ramp_cnt <= ramp_cnt + CNT_W'(1);
    end
  end

  // Signed sample around midpoint times (volume + 1), kept at full width
  always_comb begin
    d_c    = $signed({1'b0, audio_in} - MID_EXT);
    gain_c = {2'b00, cur_volume} + {{(GAIN_W-1){1'b0}}, 1'b1};
    prod_c = $signed({{(VOL_W+1){d_c[DATA_W]}}, d_c}) * $signed({{DATA_W{1'b0}}, gain_c});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_bypass <= 1'b0;
      s1_raw    <= MID;
      s1_vol    <= '0;
      s1_prod   <= '0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        s1_bypass <= ~enable_volume;
        s1_raw    <= audio_in;
        s1_vol    <= cur_volume;
        s1_prod   <= prod_c;
      end
    end
  end

  // Floor-divide by 2^VOL_W and re-centre; the top bits are pure sign extension
  always_comb begin
    sum_c         = PROD_W'(s1_prod >>> VOL_W) + PROD_W'(MID);
    unused_sum_hi = ^sum_c[PROD_W-1:DATA_W];
    scaled_c      = sum_c[DATA_W-1:0];
    if (s1_bypass) begin
      scaled_c = s1_raw;
    end else if (s1_vol == '0) begin
      scaled_c = MID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      audio_out <= MID;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        audio_out <= scaled_c;
      end
    end
  end

endmodule

// File: tb/tb_team_06_ramped_volume_ctrl.sv
// Bench for team_06_ramped_volume_ctrl: gain vector table, directed ramp/mute/
// bypass/reset sequences and a randomized run against an arithmetic reference.
module tb_team_06_ramped_volume_ctrl;

  localparam int RAMP = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       vol_up;
  logic       vol_dn;
  logic       mute;
  logic       enable_volume;
  logic       sample_valid;
  logic [7:0] audio_in;
  logic [7:0] audio_out;
  logic       out_valid;
  logic [3:0] cur_volume;
  logic       ramping;

  team_06_ramped_volume_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .vol_up       (vol_up),
    .vol_dn       (vol_dn),
    .mute         (mute),
    .enable_volume(enable_volume),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .cur_volume   (cur_volume),
    .ramping      (ramping)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int val; } exp_t;
  typedef struct { int vol; logic en; logic [7:0] ain; logic [7:0] expv; } vec_t;

  exp_t sb[$];
  int   tgt_m, cur_m, run_m, last_m, cyc;
  int   checks, errors;

  // Reference gain: midpoint plus floor((x - 128) * (vol + 1) / 16)
  function automatic int ref_gain(int ain, int vol);
    int p;
    if (vol == 0) return 128;
    p = (ain - 128) * (vol + 1);
    if (p >= 0) return 128 + p / 16;
    return 128 - ((-p + 15) / 16);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Advance the reference by one clock edge using the inputs present at that edge
  task automatic model_edge();
    int eff;
    if (rst) begin
      tgt_m = 8; cur_m = 0; run_m = 0; last_m = 128;
      sb.delete();
      return;
    end
    eff = mute ? 0 : tgt_m;
    if (sample_valid) begin
      exp_t e;
      e.due = cyc + 1;
      e.val = enable_volume ? ref_gain(int'(audio_in), cur_m) : int'(audio_in);
      sb.push_back(e);
    end
    if (cur_m == eff) begin
      run_m = 0;
    end else begin
      run_m++;
      if (run_m % RAMP == 0) cur_m += (eff > cur_m) ? 1 : -1;
    end
    if (vol_up && !vol_dn && tgt_m < 15) tgt_m++;
    if (vol_dn && !vol_up && tgt_m > 0) tgt_m--;
  endtask

  task automatic tick();
    bit exp_ov;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    exp_ov = (sb.size() > 0) && (sb[0].due == cyc);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      last_m = sb[0].val;
      void'(sb.pop_front());
    end
    check("audio_out", audio_out, last_m);
    check("cur_volume", cur_volume, cur_m);
    check("ramping", ramping, cur_m != (mute ? 0 : tgt_m));
  endtask

  task automatic pulse(input logic up, input logic dn);
    vol_up = up; vol_dn = dn;
    tick();
    vol_up = 1'b0; vol_dn = 1'b0;
  endtask

  task automatic wait_settled(input string name);
    int n = 0;
    while (ramping && n < 20000) begin
      tick();
      n++;
    end
    check(name, ramping, 0);
  endtask

  task automatic settle_volume(input int v);
    mute = 1'b0;
    while (tgt_m < v) pulse(1'b1, 1'b0);
    while (tgt_m > v) pulse(1'b0, 1'b1);
    wait_settled("settle_timeout");
    check("settle_level", cur_volume, v);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    logic [7:0] vals[20];
    int first1, first8;

    vecs[0]  = '{0,  1'b1, 8'hC0, 8'h80};
    vecs[1]  = '{3,  1'b1, 8'h40, 8'h70};
    vecs[2]  = '{3,  1'b0, 8'h40, 8'h40};
    vecs[3]  = '{7,  1'b1, 8'hC0, 8'hA0};
    vecs[4]  = '{7,  1'b1, 8'h40, 8'h60};
    vecs[5]  = '{7,  1'b1, 8'h00, 8'h40};
    vecs[6]  = '{7,  1'b1, 8'h81, 8'h80};
    vecs[7]  = '{7,  1'b1, 8'h7F, 8'h7F};
    vecs[8]  = '{15, 1'b1, 8'hC0, 8'hC0};
    vecs[9]  = '{15, 1'b1, 8'h00, 8'h00};
    vecs[10] = '{15, 1'b1, 8'hFF, 8'hFF};

    checks = 0; errors = 0; cyc = 0;
    tgt_m = 8; cur_m = 0; run_m = 0; last_m = 128;
    rst = 1'b1; vol_up = 1'b0; vol_dn = 1'b0; mute = 1'b0;
    enable_volume = 1'b1; sample_valid = 1'b0; audio_in = 8'h80;

    repeat (3) tick();
    check("rst_cur_volume", cur_volume, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_audio_out", audio_out, 8'h80);
    check("rst_ramping", ramping, 1);

    // Fade-in from reset
    rst = 1'b0;
    first1 = -1; first8 = -1;
    for (int i = 1; i <= 3000; i++) begin
      tick();
      if (cur_volume == 4'd1 && first1 < 0) first1 = i;
      if (cur_volume == 4'd8) begin
        first8 = i;
        break;
      end
    end
    check("fade_first_step", first1, 256);
    check("fade_reach_8", first8, 2048);
    check("fade_done", ramping, 0);

    // Saturation and simultaneous presses
    repeat (10) pulse(1'b1, 1'b0);
    wait_settled("sat_up_timeout");
    check("sat_up_level", cur_volume, 15);
    pulse(1'b1, 1'b1);
    check("both_pressed_top", ramping, 0);
    repeat (20) pulse(1'b0, 1'b1);
    wait_settled("sat_dn_timeout");
    check("sat_dn_level", cur_volume, 0);
    repeat (3) pulse(1'b0, 1'b1);
    check("dn_at_zero", ramping, 0);
    pulse(1'b1, 1'b1);
    check("both_pressed_zero", ramping, 0);
    repeat (300) tick();
    check("zero_hold", cur_volume, 0);

    // Gain vectors, each output exactly two cycles after its sample
    for (int i = 0; i < 11; i++) begin
      settle_volume(vecs[i].vol);
      enable_volume = vecs[i].en;
      audio_in = vecs[i].ain;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      check("vec_early_valid", out_valid, 0);
      tick();
      check("vec_valid", out_valid, 1);
      check("vec_audio_out", audio_out, vecs[i].expv);
      enable_volume = 1'b1;
    end

    // Mute ramps down one step per RAMP cycles, release ramps back up
    settle_volume(8);
    mute = 1'b1;
    for (int i = 1; i <= 3 * RAMP; i++) begin
      tick();
      if (i % RAMP == 0) check("mute_down", cur_volume, 8 - i / RAMP);
    end
    mute = 1'b0;
    for (int i = 1; i <= 3 * RAMP; i++) begin
      tick();
      if (i % RAMP == 0) check("unmute_up", cur_volume, 5 + i / RAMP);
    end
    check("unmute_done", ramping, 0);

    // Bypass with back-to-back samples
    settle_volume(3);
    enable_volume = 1'b0;
    for (int i = 0; i < 20; i++) vals[i] = 8'($urandom);
    for (int t = 0; t < 22; t++) begin
      sample_valid = (t < 20);
      audio_in = (t < 20) ? vals[t] : 8'h00;
      tick();
      if (t >= 1 && t <= 20) begin
        check("bypass_valid", out_valid, 1);
        check("bypass_data", audio_out, vals[t-1]);
      end else begin
        check("bypass_idle", out_valid, 0);
      end
    end
    sample_valid = 1'b0;
    enable_volume = 1'b1;

    // Reset one cycle after a sample discards it
    audio_in = 8'hC0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_audio", audio_out, 8'h80);
    check("midrst_cur", cur_volume, 0);
    tick();
    check("midrst_valid_late", out_valid, 0);
    check("midrst_audio_late", audio_out, 8'h80);

    // Randomized traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      vol_up = ($urandom_range(0, 79) == 0);
      vol_dn = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 399) == 0) mute = ~mute;
      enable_volume = ($urandom_range(0, 3) != 0);
      sample_valid = 1'($urandom_range(0, 1));
      audio_in = 8'($urandom);
      tick();
    end
    rst = 1'b0; vol_up = 1'b0; vol_dn = 1'b0; sample_valid = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
